// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of imem_loader.
// The master modport is the loader's view. The slave modport is the view of
// the byte source and the memory.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a program image into the instruction memory from a byte
// stream. The stream is LEN_LO, LEN_HI, then N little-endian 32-bit words.
// The loader holds the CPU in reset while a load is running.
// Optional feature: define IMEM_LOADER_CSUM_EN to require one trailer byte.
// That byte must equal the XOR of all payload bytes, and it is checked after
// the last word has been written.
module imem_loader #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic         clk,
  input  logic         res,
  input  logic         start,
  imem_loader_if.master bus,
  output logic         cpu_res,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // State entered after the last payload word has been written.
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t S_FINAL = S_CSUM;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [31:0]   MAX_WORDS = 32'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic              r_ready;
  logic              r_busy;
  logic              r_cpu_res;
  logic              r_done;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_cnt;
  logic [15:0]       r_len;
  logic [7:0]        r_len_lo;
  logic [1:0]        r_lane;
  logic [23:0]       r_asm;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_hs;
  logic [15:0]       w_len;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_last;

  assign w_hs      = bus.byte_valid && r_ready;
  assign w_len     = {bus.byte_data, r_len_lo};
  assign w_word    = {bus.byte_data, r_asm};
  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_last    = (32'(w_cnt_inc) == 32'(r_len));

  assign bus.byte_ready = r_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign cpu_res        = r_cpu_res;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;

  // The status outputs depend only on the state. Each transition loads them
  // from this table together with the new state, so they stay registered.
  // Bit order: {byte_ready, busy, cpu_res, done, err}.
  function automatic logic [4:0] f_flags(input state_t s);
    case (s)
      S_LEN_LO, S_LEN_HI, S_DATA: return 5'b11100;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM:                     return 5'b11100;
`endif
      S_DONE:                     return 5'b00010;
      S_ERR:                      return 5'b00101;
      default:                    return 5'b00000;
    endcase
  endfunction

  // Main load FSM: accepts bytes, assembles words, and issues memory writes.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_cpu_res <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_len_lo  <= '0;
      r_lane    <= '0;
      r_asm     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state <= S_LEN_LO;
            {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_LEN_LO);
            r_cnt   <= '0;
            r_len   <= '0;
            r_lane  <= '0;
            r_asm   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (w_hs) begin
            r_len_lo <= bus.byte_data;
            r_state  <= S_LEN_HI;
            {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_LEN_HI);
          end
        end
        S_LEN_HI: begin
          if (w_hs) begin
            r_len <= w_len;
            if (32'(w_len) > MAX_WORDS) begin
              r_state <= S_ERR;
              {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_ERR);
            end else if (w_len == 16'd0) begin
              r_state <= S_FINAL;
              {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_FINAL);
            end else begin
              r_state <= S_DATA;
              {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_DATA);
            end
          end
        end
        S_DATA: begin
          if (w_hs) begin
            r_lane <= r_lane + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum <= r_csum ^ bus.byte_data;
`endif
            case (r_lane)
              2'd0: r_asm[7:0]   <= bus.byte_data;
              2'd1: r_asm[15:8]  <= bus.byte_data;
              2'd2: r_asm[23:16] <= bus.byte_data;
              default: begin
                // The write is issued from this handshake, so the strobe
                // appears in the following cycle. The state moves on at the
                // same time, which keeps byte_ready low right after the last
                // word.
                r_we    <= 1'b1;
                r_addr  <= r_cnt[ADDR_W-1:0];
                r_wdata <= w_word;
                r_cnt   <= w_cnt_inc;
                if (w_last) begin
                  r_state <= S_FINAL;
                  {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_FINAL);
                end
              end
            endcase
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (w_hs) begin
            if (bus.byte_data == r_csum) begin
              r_state <= S_DONE;
              {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_DONE);
            end else begin
              r_state <= S_ERR;
              {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_ERR);
            end
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          {r_ready, r_busy, r_cpu_res, r_done, r_err} <= f_flags(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. The stimulus pushes each expected memory write
// into a queue. A monitor pops an entry and compares it whenever imem_we is
// seen.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned ADDR_W = 12;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk;
  logic res;
  logic start;
  logic cpu_res;
  logic busy;
  logic done;
  logic err;

  int unsigned n_checks;
  int unsigned n_fail;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [7:0]  tb_csum;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .res     (res),
    .start   (start),
    .bus     (bus),
    .cpu_res (cpu_res),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(mon_e.addr));
        chk("wr_data", bus.imem_wdata, mon_e.data);
      end
    end
  end

  // Each task is entered and left at a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input logic chk_cpu);
    int unsigned t;
    for (int unsigned g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      if (chk_cpu) chk("gap_cpu_res", cpu_res, 1);
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    if (chk_cpu) chk("load_cpu_res", cpu_res, 1);
    t = 0;
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.byte_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL hs_timeout: byte 0x%0h got byte_ready=%b expected 1 within 50 cycles",
               b, bus.byte_ready);
      bus.byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w,
                           input int unsigned gap, input logic chk_cpu);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_q.push_back(e);
    tb_csum = tb_csum ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    send_byte(w[7:0],   gap, chk_cpu);
    send_byte(w[15:8],  gap, chk_cpu);
    send_byte(w[23:16], gap, chk_cpu);
    send_byte(w[31:24], gap, chk_cpu);
    chk("we_latency", bus.imem_we, 1);
  endtask

  task automatic pulse_start();
    bus.byte_valid = 1'b0;
    start   = 1'b1;
    tb_csum = 8'h00;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    tb_csum        = 8'h00;
    res            = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset then idle.
    repeat (2) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_we", bus.imem_we, 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_cpu_res", cpu_res, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", bus.byte_ready, 0);
      chk("idle_busy", busy, 0);
    end
    bus.byte_valid = 1'b0;

    // Two-word load with back-to-back bytes.
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_cpu_res", cpu_res, 1);
    chk("start_ready", bus.byte_ready, 1);
    send_byte(8'h02, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_word(12'd0, 32'h0010_0513, 0, 1'b1);
    chk("mid_cpu_res", cpu_res, 1);
    send_word(12'd1, 32'h0020_0593, 0, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    chk("csum_cpu_res", cpu_res, 1);
    send_byte(8'hB0, 0, 1'b1);
`endif
    chk("b2b_done", done, 1);
    chk("b2b_cpu_res", cpu_res, 0);
    chk("b2b_busy", busy, 0);
    chk("b2b_ready", bus.byte_ready, 0);

    // The same image again, with 3 idle cycles before every byte.
    pulse_start();
    chk("restart_done_clr", done, 0);
    send_byte(8'h02, 3, 1'b1);
    send_byte(8'h00, 3, 1'b1);
    send_word(12'd0, 32'h0010_0513, 3, 1'b1);
    send_word(12'd1, 32'h0020_0593, 3, 1'b1);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(tb_csum, 3, 1'b1);
`endif
    chk("gap_done", done, 1);
    chk("gap_cpu_res_end", cpu_res, 0);

    // A length of zero.
    pulse_start();
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h00, 0, 1'b1);
`endif
    chk("n0_we", bus.imem_we, 0);
    chk("n0_done", done, 1);

    // Oversize length (4097 words) is rejected.
    pulse_start();
    send_byte(8'h01, 0, 1'b1);
    send_byte(8'h10, 0, 1'b1);
    chk("big_err", err, 1);
    chk("big_cpu_res", cpu_res, 1);
    chk("big_busy", busy, 0);
    chk("big_done", done, 0);
    chk("big_ready", bus.byte_ready, 0);
    pulse_start();
    chk("err_clr", err, 0);
    chk("err_clr_busy", busy, 1);

    // A full-capacity load of 4096 words ends at the last address and does not wrap.
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h10, 0, 1'b1);
    chk("max_err", err, 0);
    chk("max_busy", busy, 1);
    for (int unsigned i = 0; i < 4096; i++) begin
      send_word(ADDR_W'(i), {8'(i), 8'(i >> 8), 8'hA5, 8'(~i)}, 0, 1'b0);
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(tb_csum, 0, 1'b1);
`endif
    chk("max_done", done, 1);
    chk("max_err_end", err, 0);

    // Reset two bytes into word 1 discards the partial word.
    pulse_start();
    send_byte(8'h02, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_word(12'd0, 32'hDEAD_BEEF, 0, 1'b1);
    send_byte(8'h11, 0, 1'b1);
    send_byte(8'h22, 0, 1'b1);
    res = 1'b0;
    #1;
    chk("mrst_cpu_res", cpu_res, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", bus.byte_ready, 0);
    chk("mrst_we", bus.imem_we, 0);
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h33;
    repeat (4) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("mrst_idle_busy", busy, 0);
    chk("mrst_idle_done", done, 0);

`ifdef IMEM_LOADER_CSUM_EN
    // A wrong checksum trailer ends in an error after the word has been written.
    pulse_start();
    send_byte(8'h01, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_word(12'd0, 32'h1234_5678, 0, 1'b1);
    send_byte(tb_csum ^ 8'h01, 0, 1'b1);
    chk("csum_bad_err", err, 1);
    chk("csum_bad_cpu_res", cpu_res, 1);
    chk("csum_bad_done", done, 0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
